// File: rtl/spi_tx_arbiter_if.sv
// Request/grant/serial bundle between two producers and the shared MSB-first transmitter.
// The slave modport is the arbiter side, the master modport is the producer side.
interface spi_tx_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_req0;
  logic [WIDTH-1:0] i_data0;
  logic             i_req1;
  logic [WIDTH-1:0] i_data1;
  logic             o_gnt0;
  logic             o_gnt1;
  logic             o_ack0;
  logic             o_ack1;
  logic             o_bit;
  logic             o_valid;
  logic             o_stop;

  modport slave (
    input  i_req0, i_data0, i_req1, i_data1,
    output o_gnt0, o_gnt1, o_ack0, o_ack1, o_bit, o_valid, o_stop
  );

  modport master (
    output i_req0, i_data0, i_req1, i_data1,
    input  o_gnt0, o_gnt1, o_ack0, o_ack1, o_bit, o_valid, o_stop
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter in front of one MSB-first serial transmitter; a frame is
// WIDTH data cycles, one ack cycle, then one gap cycle before the next grant.
module spi_tx_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_tx_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       r_state, w_state;
  logic [CW-1:0]    r_cnt,   w_cnt;
  logic [WIDTH-1:0] r_sreg,  w_sreg;
  logic             r_last,  w_last;
  logic             r_gnt0,  w_gnt0;
  logic             r_gnt1,  w_gnt1;
  logic             r_ack0,  w_ack0;
  logic             r_ack1,  w_ack1;
  logic             r_bit,   w_bit;
  logic             r_valid, w_valid;
  logic             r_stop,  w_stop;

  logic             w_pick1;
  logic [WIDTH-1:0] w_data;

  // On a tie the port that was not served last wins.
  always_comb begin
    w_pick1 = bus.i_req1;
    if (bus.i_req0 && bus.i_req1) begin
      w_pick1 = ~r_last;
    end
    w_data = w_pick1 ? bus.i_data1 : bus.i_data0;
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sreg  = r_sreg;
    w_last  = r_last;
    w_gnt0  = r_gnt0;
    w_gnt1  = r_gnt1;
    w_ack0  = r_ack0;
    w_ack1  = r_ack1;
    w_bit   = r_bit;
    w_valid = r_valid;
    w_stop  = r_stop;

    case (r_state)
      S_IDLE: begin
        if (bus.i_req0 || bus.i_req1) begin
          w_gnt0  = ~w_pick1;
          w_gnt1  = w_pick1;
          w_bit   = w_data[WIDTH-1];
          w_sreg  = w_data << 1;
          w_valid = 1'b1;
          w_stop  = 1'b0;
          w_cnt   = CW'(1);
          w_last  = w_pick1;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt < CW'(WIDTH)) begin
          w_bit  = r_sreg[WIDTH-1];
          w_sreg = r_sreg << 1;
          w_cnt  = r_cnt + CW'(1);
        end else begin
          w_valid = 1'b0;
          w_stop  = 1'b1;
          w_gnt0  = 1'b0;
          w_gnt1  = 1'b0;
          w_ack0  = r_gnt0;
          w_ack1  = r_gnt1;
          w_bit   = 1'b0;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Reset aborts any frame in flight without an ack and re-arms port 0 for the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_stop  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sreg  <= w_sreg;
      r_last  <= w_last;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_bit   <= w_bit;
      r_valid <= w_valid;
      r_stop  <= w_stop;
    end
  end

  assign bus.o_gnt0  = r_gnt0;
  assign bus.o_gnt1  = r_gnt1;
  assign bus.o_ack0  = r_ack0;
  assign bus.o_ack1  = r_ack1;
  assign bus.o_bit   = r_bit;
  assign bus.o_valid = r_valid;
  assign bus.o_stop  = r_stop;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: stimulus queues expected serial bits per frame,
// a negedge monitor pops and compares them, plus ack, grant spacing and output invariants.
module tb_spi_tx_arbiter;

  typedef struct {
    logic port;
    logic b;
    logic first;
    logic last;
    int   period;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.WIDTH(8)) b8 ();
  spi_tx_arbiter_if #(.WIDTH(4)) b4 ();

  spi_tx_arbiter #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  spi_tx_arbiter #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int   cyc[2]        = '{0, 0};
  int   last_start[2] = '{0, 0};
  logic prev_valid[2] = '{1'b0, 1'b0};
  logic ack_exp[2]    = '{1'b0, 1'b0};
  logic ack_port[2]   = '{1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the first nbits of a frame (MSB first); ack expected only if the LSB is queued.
  task automatic push_frame(input int k, input logic port, input logic [31:0] d,
                            input int w, input int nbits, input int period);
    exp_t e;
    for (int i = w - 1; i >= w - nbits; i--) begin
      e.port   = port;
      e.b      = d[i];
      e.first  = (i == w - 1);
      e.last   = (i == 0);
      e.period = (i == w - 1) ? period : 0;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic check_cycle(input int k, input logic g0, input logic g1, input logic a0,
                             input logic a1, input logic b, input logic v, input logic s);
    exp_t e;
    int   sz;
    cyc[k]++;
    chk("inv_valid", int'(v), int'(g0 | g1));
    chk("inv_stop", int'(s), int'(!v));
    chk("inv_gnt_onehot", int'(g0 & g1), 0);
    if (ack_exp[k]) chk("ack", int'({a1, a0}), ack_port[k] ? 2 : 1);
    else            chk("no_ack", int'({a1, a0}), 0);
    ack_exp[k] = 1'b0;
    if (v) begin
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("bit", int'(b), int'(e.b));
        chk("gnt_port", int'({g1, g0}), e.port ? 2 : 1);
        chk("frame_start", int'(!prev_valid[k]), int'(e.first));
        if (e.first && e.period != 0) chk("grant_period", cyc[k] - last_start[k], e.period);
        if (e.first) last_start[k] = cyc[k];
        if (e.last) begin
          ack_exp[k]  = 1'b1;
          ack_port[k] = e.port;
        end
      end
    end else begin
      chk("idle_bit", int'(b), 0);
    end
    prev_valid[k] = v;
  endtask

  always @(negedge clk) begin
    check_cycle(0, b8.o_gnt0, b8.o_gnt1, b8.o_ack0, b8.o_ack1, b8.o_bit, b8.o_valid, b8.o_stop);
    check_cycle(1, b4.o_gnt0, b4.o_gnt1, b4.o_ack0, b4.o_ack1, b4.o_bit, b4.o_valid, b4.o_stop);
  end

  task automatic chk_idle8(input string name);
    chk({name, "_valid"}, int'(b8.o_valid), 0);
    chk({name, "_stop"}, int'(b8.o_stop), 1);
    chk({name, "_gnt"}, int'({b8.o_gnt1, b8.o_gnt0}), 0);
    chk({name, "_ack"}, int'({b8.o_ack1, b8.o_ack0}), 0);
    chk({name, "_bit"}, int'(b8.o_bit), 0);
  endtask

  initial begin
    b8.i_req0 = 1'b0; b8.i_req1 = 1'b0; b8.i_data0 = '0; b8.i_data1 = '0;
    b4.i_req0 = 1'b0; b4.i_req1 = 1'b0; b4.i_data0 = '0; b4.i_data1 = '0;
    rst = 1'b1;
    tick(2);
    chk_idle8("reset");
    rst = 1'b0;

    // Single request, A5 -> 1,0,1,0,0,1,0,1 then ack0.
    push_frame(0, 1'b0, 32'hA5, 8, 8, 0);
    b8.i_data0 = 8'hA5; b8.i_req0 = 1'b1;
    tick(1);
    b8.i_req0 = 1'b0;
    tick(12);

    // Fresh pointer, both requesting: port 0, port 1, port 0, ten cycles apart.
    rst = 1'b1; tick(1); rst = 1'b0;
    push_frame(0, 1'b0, 32'h0F, 8, 8, 0);
    push_frame(0, 1'b1, 32'hF0, 8, 8, 10);
    push_frame(0, 1'b0, 32'h0F, 8, 8, 10);
    b8.i_data0 = 8'h0F; b8.i_data1 = 8'hF0;
    b8.i_req0 = 1'b1; b8.i_req1 = 1'b1;
    tick(1);
    tick(20);
    b8.i_req0 = 1'b0; b8.i_req1 = 1'b0;
    tick(12);

    // Mid-frame data change is ignored; the next frame picks up the new word.
    push_frame(0, 1'b1, 32'h35, 8, 8, 0);
    push_frame(0, 1'b1, 32'hCC, 8, 8, 10);
    b8.i_data1 = 8'h35; b8.i_req1 = 1'b1;
    tick(1);
    tick(2);
    b8.i_data1 = 8'hCC;
    tick(8);
    b8.i_req1 = 1'b0;
    tick(12);

    // Port 0 drops req mid-frame; late port 1 request granted WIDTH+2 after.
    push_frame(0, 1'b0, 32'h3C, 8, 8, 0);
    push_frame(0, 1'b1, 32'h81, 8, 8, 10);
    b8.i_data0 = 8'h3C; b8.i_req0 = 1'b1;
    tick(1);
    tick(1);
    b8.i_req0 = 1'b0;
    b8.i_data1 = 8'h81; b8.i_req1 = 1'b1;
    tick(9);
    b8.i_req1 = 1'b0;
    tick(12);

    // Reset after 4 bits of 29 aborts silently; restart and port 0 wins the tie.
    push_frame(0, 1'b0, 32'h29, 8, 4, 0);
    b8.i_data0 = 8'h29; b8.i_req0 = 1'b1;
    tick(1);
    tick(3);
    rst = 1'b1;
    b8.i_data1 = 8'h77; b8.i_req1 = 1'b1;
    tick(1);
    chk_idle8("abort");
    rst = 1'b0;
    push_frame(0, 1'b0, 32'h29, 8, 8, 0);
    push_frame(0, 1'b1, 32'h77, 8, 8, 10);
    tick(1);
    tick(10);
    b8.i_req0 = 1'b0; b8.i_req1 = 1'b0;
    tick(12);

    // WIDTH=4 instance: 1001 then 0110, period 6.
    push_frame(1, 1'b0, 32'h9, 4, 4, 0);
    push_frame(1, 1'b0, 32'h6, 4, 4, 6);
    b4.i_data0 = 4'b1001; b4.i_req0 = 1'b1;
    tick(1);
    b4.i_data0 = 4'b0110;
    tick(6);
    b4.i_req0 = 1'b0;
    tick(8);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
